// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer: splits 64-bit fetch beats into two 32-bit instructions with PC and type code
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   fetch_addr            8-byte-aligned address of the beat wanted next
//   bus_ready/bus_valid   beat handshake, bus_data[31:0] = instr at fetch_addr, [63:32] = fetch_addr+4
//   instruction, instruction_type, pc, out_valid, out_ready
//                         decode-side handshake, outputs driven from registers
//   redirect_valid/_pc    flush and restart fetch at redirect_pc (bits [1:0] ignored)
//   halted                high while stopped on a zero instruction
// Optional: define HALT_ON_ZERO_EN to stop after a 32'h00000000 instruction is consumed.

`ifndef R_TYPE
`define R_TYPE  3'd0
`endif
`ifndef I_TYPE
`define I_TYPE  3'd1
`endif
`ifndef S_TYPE
`define S_TYPE  3'd2
`endif
`ifndef SB_TYPE
`define SB_TYPE 3'd3
`endif
`ifndef U_TYPE
`define U_TYPE  3'd4
`endif
`ifndef UJ_TYPE
`define UJ_TYPE 3'd5
`endif

module fetch_align_buffer #(
    parameter int INSTRUCTION_LENGTH = 32,
    parameter int BUS_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int TYPE_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic [ADDR_WIDTH-1:0]         fetch_addr,
    output logic                          bus_ready,
    input  logic                          bus_valid,
    input  logic [BUS_WIDTH-1:0]          bus_data,
    output logic [INSTRUCTION_LENGTH-1:0] instruction,
    output logic [TYPE_WIDTH-1:0]         instruction_type,
    output logic [ADDR_WIDTH-1:0]         pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          redirect_valid,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc,
    output logic                          halted
);
    typedef enum logic [1:0] {EMPTY, LOW, HIGH, HALTED} state_t;
    state_t state;
    logic [ADDR_WIDTH-1:0] pc_q, pc_inc, fetch_base;
    logic [BUS_WIDTH-1:0] word;
    logic fire, accept, halt_now;
    logic [6:0] opcode;
    assign pc_inc = pc_q + ADDR_WIDTH'(4);
    assign out_valid = (state == LOW) | (state == HIGH);
    // In HIGH the next beat can land in the same cycle the upper half is consumed
    assign bus_ready = (state == EMPTY) | ((state == HIGH) & out_ready);
    assign fire = out_valid & out_ready;
    assign accept = bus_valid & bus_ready & ~redirect_valid;
    assign instruction = (state == HIGH) ? word[BUS_WIDTH-1:INSTRUCTION_LENGTH] : word[INSTRUCTION_LENGTH-1:0];
    assign pc = pc_q;
    assign fetch_base = (state == HIGH) ? pc_inc : pc_q;
    assign fetch_addr = fetch_base & ~ADDR_WIDTH'(7);
    assign opcode = instruction[6:0];
`ifdef HALT_ON_ZERO_EN
    assign halt_now = fire & (instruction == '0);
    assign halted = (state == HALTED);
`else
    assign halt_now = 1'b0;
    assign halted = 1'b0;
`endif
    always_comb begin
        case (opcode)
            7'b0110011, 7'b0111011: instruction_type = `R_TYPE;
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: instruction_type = `I_TYPE;
            7'b0100011: instruction_type = `S_TYPE;
            7'b1100011: instruction_type = `SB_TYPE;
            7'b0110111, 7'b0010111: instruction_type = `U_TYPE;
            7'b1101111: instruction_type = `UJ_TYPE;
            default: instruction_type = 3'b111;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
            pc_q <= RESET_PC;
            word <= '0;
        end else if (redirect_valid) begin
            // A same-cycle fire is still consumed by decode but pc_q restarts here
            state <= EMPTY;
            pc_q <= redirect_pc & ~ADDR_WIDTH'(3);
        end else begin
            if (fire)
                pc_q <= pc_inc;
            if (accept)
                word <= bus_data;
            case (state)
                // Entering at an odd word skips the lower half of the beat
                EMPTY: if (accept) state <= pc_q[2] ? HIGH : LOW;
                LOW: if (fire) state <= halt_now ? HALTED : HIGH;
                HIGH: if (fire) state <= halt_now ? HALTED : (accept ? LOW : EMPTY);
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_align_buffer.sv
// tb_fetch_align_buffer: directed self-checking bench for fetch_align_buffer

`ifndef R_TYPE
`define R_TYPE  3'd0
`endif
`ifndef I_TYPE
`define I_TYPE  3'd1
`endif
`ifndef S_TYPE
`define S_TYPE  3'd2
`endif
`ifndef SB_TYPE
`define SB_TYPE 3'd3
`endif
`ifndef U_TYPE
`define U_TYPE  3'd4
`endif
`ifndef UJ_TYPE
`define UJ_TYPE 3'd5
`endif

module tb_fetch_align_buffer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [63:0] fetch_addr, pc, redirect_pc = '0;
    logic [63:0] bus_data = '0;
    logic bus_ready, bus_valid = 1'b0, out_valid, out_ready = 1'b0, redirect_valid = 1'b0, halted;
    logic [31:0] instruction;
    logic [2:0] instruction_type;
    int n_cmp = 0, n_bad = 0;

    fetch_align_buffer dut (
        .clk(clk), .reset_n(reset_n), .fetch_addr(fetch_addr), .bus_ready(bus_ready),
        .bus_valid(bus_valid), .bus_data(bus_data), .instruction(instruction),
        .instruction_type(instruction_type), .pc(pc), .out_valid(out_valid),
        .out_ready(out_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] ins(input logic [63:0] a);
        return {a[11:0], 20'h00013};
    endfunction

    function automatic logic [63:0] beat(input logic [63:0] a);
        return {ins(a + 64'd4), ins(a)};
    endfunction

    function automatic logic [63:0] opb(input logic [6:0] hi, input logic [6:0] lo);
        return {25'h0, hi, 25'h0, lo};
    endfunction

    task automatic redirect(input logic [63:0] a);
        redirect_valid = 1'b1;
        redirect_pc = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    logic [63:0] sweep_beats [5];
    logic [2:0]  sweep_types [10];

    initial begin
        sweep_beats = '{opb(7'h63, 7'h23), opb(7'h6F, 7'h37), opb(7'h7F, 7'h33),
                        opb(7'h67, 7'h3B), opb(7'h73, 7'h17)};
        sweep_types = '{`S_TYPE, `SB_TYPE, `U_TYPE, `UJ_TYPE, `R_TYPE, 3'b111,
                        `R_TYPE, `I_TYPE, `U_TYPE, `I_TYPE};
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fetch_addr", fetch_addr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_bus_ready", bus_ready, 1);
        reset_n = 1'b1;
        bus_valid = 1'b1;
        bus_data = 64'h00500093_00000013;
        out_ready = 1'b1;
        tick();
        bus_valid = 1'b0;
        chk("first_valid", out_valid, 1);
        chk("first_instr", instruction, 32'h00000013);
        chk("first_type", instruction_type, `I_TYPE);
        chk("first_pc", pc, 0);
        #1 chk("low_bus_ready", bus_ready, 0);
        tick();
        chk("second_instr", instruction, 32'h00500093);
        chk("second_pc", pc, 4);
        chk("high_fetch_addr", fetch_addr, 8);
        #1 chk("high_bus_ready", bus_ready, 1);

        redirect(64'h0);
        chk("stream_empty", out_valid, 0);
        chk("stream_fetch0", fetch_addr, 0);
        for (int c = 0; c <= 8; c++) begin
            bus_valid = (c < 8);
            bus_data = (c % 2 == 0) ? beat(64'(4 * c)) : 64'hDEADBEEF_DEADBEEF;
            #1;
            if (c >= 1) begin
                chk("stream_valid", out_valid, 1);
                chk("stream_pc", pc, 64'(4 * (c - 1)));
                chk("stream_instr", instruction, ins(64'(4 * (c - 1))));
                chk("stream_bus_ready", bus_ready, (c % 2 == 0));
            end
            tick();
        end
        bus_valid = 1'b0;
        chk("stream_drain", out_valid, 0);
        chk("stream_fetch32", fetch_addr, 32);

        bus_valid = 1'b1;
        bus_data = beat(64'd32);
        out_ready = 1'b0;
        tick();
        bus_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_pc", pc, 32);
            chk("bp_instr", instruction, ins(64'd32));
            chk("bp_bus_ready", bus_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_release_instr", instruction, ins(64'd32));
        tick();
        chk("bp_next_pc", pc, 36);
        chk("bp_next_instr", instruction, ins(64'd36));
        tick();

        bus_valid = 1'b1;
        bus_data = beat(64'd40);
        tick();
        bus_valid = 1'b0;
        tick();
        chk("pre_redir_pc", pc, 44);
        bus_valid = 1'b1;
        bus_data = 64'hBAD0BAD0_BAD0BAD0;
        redirect(64'h106);
        chk("redir_valid", out_valid, 0);
        chk("redir_fetch", fetch_addr, 64'h100);
        chk("redir_pc", pc, 64'h104);
        bus_data = beat(64'h100);
        #1 chk("redir_bus_ready", bus_ready, 1);
        tick();
        bus_valid = 1'b0;
        chk("redir_out_valid", out_valid, 1);
        chk("redir_out_pc", pc, 64'h104);
        chk("redir_out_instr", instruction, ins(64'h104));
        #1 chk("redir_hi_bus_ready", bus_ready, 1);
        tick();
        chk("redir_drain", out_valid, 0);
        chk("redir_fetch_next", fetch_addr, 64'h108);

        redirect(64'h200);
        for (int b = 0; b < 5; b++) begin
            bus_valid = 1'b1;
            bus_data = sweep_beats[b];
            tick();
            bus_valid = 1'b0;
            chk("sweep_type_lo", instruction_type, sweep_types[2 * b]);
            tick();
            chk("sweep_type_hi", instruction_type, sweep_types[2 * b + 1]);
            tick();
        end

        redirect(64'h300);
        bus_valid = 1'b1;
        bus_data = 64'h00000013_00000000;
        tick();
        bus_valid = 1'b0;
        chk("zero_instr", instruction, 0);
        chk("zero_type", instruction_type, 3'b111);
        tick();
`ifdef HALT_ON_ZERO_EN
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("halt_halted", halted, 1);
            chk("halt_out_valid", out_valid, 0);
            chk("halt_bus_ready", bus_ready, 0);
            tick();
        end
        redirect(64'h40);
        chk("halt_exit", halted, 0);
        chk("halt_fetch", fetch_addr, 64'h40);
`else
        chk("nohalt_valid", out_valid, 1);
        chk("nohalt_instr", instruction, 32'h00000013);
        chk("nohalt_pc", pc, 64'h304);
        chk("nohalt_halted", halted, 0);
        tick();
        redirect(64'h40);
        chk("nohalt_fetch", fetch_addr, 64'h40);
`endif

        bus_valid = 1'b1;
        bus_data = beat(64'h40);
        tick();
        bus_valid = 1'b0;
        chk("resume_pc", pc, 64'h40);
        chk("resume_instr", instruction, ins(64'h40));
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_pc", pc, 0);
        chk("async_rst_instr", instruction, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
Upstream neighbour of the field-extraction decode stage. Accepts 64-bit instruction-memory beats, splits each into two 32-bit RV instructions in program order, and classifies each opcode into the codebase's instruction-type code. Each instruction is presented with its PC over a valid/ready handshake. Branch/jump redirects flush the buffer and restart fetch.

Parameters:
INSTRUCTION_LENGTH, 32, width of one instruction.
BUS_WIDTH, 64, memory beat width (two instructions per beat).
ADDR_WIDTH, 64, PC/fetch address width.
TYPE_WIDTH, 3, instruction-type code width.
RESET_PC, 64'h0, first fetch PC after reset.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
fetch_addr  output  ADDR_WIDTH  8-byte-aligned address of the beat wanted next
bus_ready  output  1  block can accept a beat this cycle
bus_valid  input  1  bus_data holds the beat for fetch_addr
bus_data  input  BUS_WIDTH  [31:0] = instr at fetch_addr, [63:32] = instr at fetch_addr+4
instruction  output  INSTRUCTION_LENGTH  current instruction to decode
instruction_type  output  TYPE_WIDTH  type code for instruction
pc  output  ADDR_WIDTH  address of instruction
out_valid  output  1  instruction/instruction_type/pc valid
out_ready  input  1  decode accepts this cycle
redirect_valid  input  1  flush and restart at redirect_pc
redirect_pc  input  ADDR_WIDTH  new PC; bits [1:0] ignored (treated as 0)
halted  output  1  see Optional Feature

Behaviour:
- Storage: one 64-bit word register plus a half-select bit. States: EMPTY, LOW (lower half valid), HIGH (only upper half valid), HALTED (optional).
- Reset (async, reset_n low): state EMPTY; pc_q = RESET_PC; word = 0; out_valid = 0; halted = 0; fetch_addr = {RESET_PC[ADDR_WIDTH-1:3], 3'b0}.
- bus_ready = (state==EMPTY) | (state==HIGH & out_ready). Beat accepted on bus_valid & bus_ready & !redirect_valid.
- Beat accept: the next state is LOW if pc_q[2]==0, HIGH if pc_q[2]==1 (entry at an odd word skips the lower half). Latency: beat accepted in cycle N gives out_valid=1 in cycle N+1.
- Outputs come from registers only. out_valid = state in {LOW, HIGH}. instruction = word[31:0] in LOW, word[63:32] in HIGH. pc = pc_q.
- Handshake fire = out_valid & out_ready. On fire, pc_q += 4.
  - LOW -> HIGH.
  - HIGH -> LOW if a beat is accepted the same cycle, else EMPTY. This sustains 1 instruction/cycle with no bubble.
- fetch_addr = {pc_q[ADDR_WIDTH-1:3], 3'b0} in EMPTY. In HIGH it is the next aligned word (pc_q+4 aligned).
- Outputs hold stable while out_valid & !out_ready.
- instruction_type is combinational from instruction[6:0]:
  - 0110011, 0111011 -> `R_TYPE
  - 0000011, 0010011, 0011011, 1100111, 1110011 -> `I_TYPE
  - 0100011 -> `S_TYPE
  - 1100011 -> `SB_TYPE
  - 0110111, 0010111 -> `U_TYPE
  - 1101111 -> `UJ_TYPE
  - any other opcode -> 3'b111 (invalid)
- Redirect has priority over everything:
  - Next cycle: state EMPTY, pc_q = {redirect_pc[ADDR_WIDTH-1:2], 2'b0}, out_valid = 0.
  - A beat presented in the same cycle is dropped.
  - A fire in the same cycle still counts as consumed by decode, but does not advance pc_q.
  - Redirect also exits HALTED.
- pc_q wraps modulo 2^ADDR_WIDTH. No error is raised.
- reset_n asserting mid-stream discards the buffered word immediately, without waiting for a clock edge.

Optional Feature:
HALT_ON_ZERO_EN.
- Defined: when the instruction 32'h00000000 fires, the next state is HALTED. In HALTED, out_valid = 0, bus_ready = 0, and halted = 1 until redirect_valid or reset. Any remaining upper half is discarded.
- Undefined: no HALTED state. Zero words pass through with type 3'b111, and halted is tied to 0.

Test Plan:
- Reset, RESET_PC=0. Beat 64'h00500093_00000013 accepted cycle 1, out_ready=1 -> cycle 2: instruction 32'h00000013, `I_TYPE, pc 0. Cycle 3: 32'h00500093, pc 4. bus_ready high in cycle 3.
- Streaming: 4 back-to-back beats, out_ready=1 -> 8 instructions on 8 consecutive cycles, pc 0..28 step 4, no bubble.
- Backpressure: out_ready=0 for 5 cycles while in LOW -> outputs unchanged, bus_ready=0. Release -> resumes with the same instruction.
- Redirect to 0x104 while in HIGH, with bus_valid high the same cycle -> next cycle out_valid=0, beat dropped, fetch_addr 0x100. After the 0x100 beat: first output pc 0x104 = upper half, then bus_ready=1.
- Opcode sweep of 0x23, 0x63, 0x37, 0x6F, 0x33, 0x7F -> `S_TYPE, `SB_TYPE, `U_TYPE, `UJ_TYPE, `R_TYPE, 3'b111.
- HALT_ON_ZERO_EN: beat 64'h00000013_00000000 -> first fire, then halted=1, out_valid=0, and the upper half is never presented. Redirect to 0x40 -> halted=0, fetch resumes at 0x40. Without the macro, both halves emerge and halted stays 0.
